// File: rtl/shadow_stack_check.sv
// Hardware shadow stack for MIPS return addresses: JAL/JALR push PC+8, JR $ra pops,
// and the word after the return's delay slot must sit at the popped address.
module shadow_stack_check #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int HALT_ON_ALARM = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_in_valid,
  input  logic [63:0]   i_in_word,
  output logic          o_in_ready,
  output logic          o_alarm,
  output logic          o_alarm_pulse,
  output logic [31:0]   o_alarm_pc,
  output logic [31:0]   o_alarm_expected,
  output logic [AW:0]   o_depth,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DELAY  = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [31:0]   r_stack [DEPTH];
  logic [AW-1:0] r_sp;
  logic [AW:0]   r_depth;
  logic [31:0]   r_exp;
  logic          r_alarm;
  logic          r_alarm_pulse;
  logic [31:0]   r_alarm_pc;
  logic [31:0]   r_alarm_expected;
  logic          r_overflow;
  logic          r_underflow;

  logic [31:0]   w_pc;
  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic [4:0]    w_rs;
  logic          w_call;
  logic          w_ret;
  logic          w_accept;
  logic          w_not_delay;
  logic          w_push;
  logic          w_pop;
  logic          w_udf;
  logic          w_mismatch;
  logic [AW-1:0] w_sp_m1;

  // Handshake: a word transfers on the cycle i_in_valid & o_in_ready are both high;
  // an all-zero word is a bubble and is consumed without effect.
  assign o_in_ready = ~((HALT_ON_ALARM != 0) & r_alarm);
  assign w_accept   = i_in_valid & o_in_ready & (i_in_word != 64'd0);

  assign w_pc    = i_in_word[63:32];
  assign w_op    = i_in_word[31:26];
  assign w_fn    = i_in_word[5:0];
  assign w_rs    = i_in_word[25:21];
  assign w_call  = (w_op == 6'd3) | ((w_op == 6'd0) & (w_fn == 6'd9));
  assign w_ret   = (w_op == 6'd0) & (w_fn == 6'd8) & (w_rs == 5'd31);
  assign w_sp_m1 = r_sp - AW'(1);

  // A return sitting in a delay slot is not honoured; calls are honoured everywhere.
  assign w_not_delay = (r_state != ST_DELAY);
  assign w_push      = w_accept & w_call;
  assign w_pop       = w_accept & w_not_delay & w_ret & (r_depth != '0);
  assign w_udf       = w_accept & w_not_delay & w_ret & (r_depth == '0);
  assign w_mismatch  = w_accept & (r_state == ST_CHECK) & (w_pc != r_exp);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_state          <= ST_NORMAL;
      r_sp             <= '0;
      r_depth          <= '0;
      r_exp            <= '0;
      r_alarm          <= 1'b0;
      r_alarm_pulse    <= 1'b0;
      r_alarm_pc       <= '0;
      r_alarm_expected <= '0;
      r_overflow       <= 1'b0;
      r_underflow      <= 1'b0;
    end else begin
      r_alarm_pulse <= 1'b0;
      if (w_mismatch) begin
        r_alarm_pulse    <= 1'b1;
        r_alarm          <= 1'b1;
        r_alarm_pc       <= w_pc;
        r_alarm_expected <= r_exp;
      end
      // When full the write pointer wraps onto the oldest entry, so depth saturates.
      if (w_push) begin
        r_sp <= r_sp + AW'(1);
        if (r_depth == FULL) r_overflow <= 1'b1;
        else                 r_depth    <= r_depth + (AW+1)'(1);
      end else if (w_pop) begin
        r_sp    <= w_sp_m1;
        r_depth <= r_depth - (AW+1)'(1);
        r_exp   <= r_stack[w_sp_m1];
      end
      if (w_udf) r_underflow <= 1'b1;
      if (w_accept) begin
        case (r_state)
          ST_DELAY: r_state <= ST_CHECK;
          default:  r_state <= w_pop ? ST_DELAY : ST_NORMAL;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_clear && w_push) r_stack[r_sp] <= w_pc + 32'd8;
  end

  assign o_alarm          = r_alarm;
  assign o_alarm_pulse    = r_alarm_pulse;
  assign o_alarm_pc       = r_alarm_pc;
  assign o_alarm_expected = r_alarm_expected;
  assign o_depth          = r_depth;
  assign o_overflow       = r_overflow;
  assign o_underflow      = r_underflow;
  assign o_dbg_state      = r_state;

endmodule
